pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the five-stage MIPS core (D/E, E/M, M/W). Replaces the per-stage hand-written registers.
- Carries a generic payload plus the hazard-control fields (A3, RFen, Tnew, PC) and a valid bit.
- Adds stall (hold), flush (bubble insertion with optional PC retention) and saturating Tnew countdown, so every stage boundary uses one block.

---
 rtl/pipe_stage_reg_pkg.sv | 59 +++++
 rtl/pipe_stage_reg_sat_dec.sv | 19 +
 rtl/pipe_stage_reg.sv | 83 ++++++++
 tb/tb_pipe_stage_reg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared definitions for the five-stage MIPS pipeline registers:
// hazard-field widths, reset PC, the zero register and per-stage bundles.
package mips_pipe_defs;

  // Width of the Tnew hazard field carried by every stage register.
  localparam int TNEW_W = 3;

  // Default opaque payload width for a stage register.
  localparam int DEFAULT_PAYLOAD_W = 64;

  // PC value loaded by reset (start of the MARS text segment).
  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  // Register $zero never creates a real write.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Register-file write-data source selected in the W stage.
  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC8 = 2'd2
  } wdsel_e;

  // D -> E bundle: fetched instruction and its link address.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc8;
  } de_bundle_t;

  // E -> M bundle: ALU result, store data and source register numbers.
  typedef struct packed {
    wdsel_e      wdsel;
    logic        dmen;
    logic [31:0] alu_out;
    logic [31:0] rd2;
    logic [4:0]  a1;
    logic [4:0]  a2;
  } em_bundle_t;

  // M -> W bundle: both candidate write-back values.
  typedef struct packed {
    wdsel_e      wdsel;
    logic [31:0] alu_out;
    logic [31:0] dm_rd;
  } mw_bundle_t;

  // Payload widths each stage register is instantiated with.
  localparam int DE_PAYLOAD_W = $bits(de_bundle_t);
  localparam int EM_PAYLOAD_W = $bits(em_bundle_t);
  localparam int MW_PAYLOAD_W = $bits(mw_bundle_t);

  // True when a valid instruction will write a register other than $zero.
  function automatic logic is_real_write(input logic valid,
                                         input logic rfen,
                                         input logic [4:0] a3);
    return valid & rfen & (a3 != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_dec.sv
// Saturating decrement: subtracts one when enabled, but never wraps below
// zero. Shared by the stage registers and the hazard unit.
module sat_dec #(
  parameter int W = 3
) (
  input  logic         dec_en,
  input  logic [W-1:0] value,
  output logic [W-1:0] result
);

  // Decrement only a non-zero value so zero stays zero instead of wrapping.
  always_comb begin
    result = value;
    if (dec_en && (value != '0)) begin
      result = value - W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register (D/E, E/M, M/W) carrying an opaque
// payload plus the hazard fields A3, RFen, Tnew, PC and a valid bit, with
// stall, flush (bubble) and a saturating Tnew countdown.
module pipe_stage_reg
  import mips_pipe_defs::*;
#(
  parameter int          PAYLOAD_W        = mips_pipe_defs::DEFAULT_PAYLOAD_W,
  parameter int          TNEW_W           = mips_pipe_defs::TNEW_W,
  parameter bit          DEC_TNEW         = 1'b1,
  parameter bit          KEEP_PC_ON_FLUSH = 1'b0,
  parameter logic [31:0] PC_RESET         = mips_pipe_defs::PC_RESET
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 flush,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic [4:0]           in_a3,
  input  logic                 in_rfen,
  input  logic [TNEW_W-1:0]    in_tnew,
  input  logic [31:0]          in_pc,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [4:0]           out_a3,
  output logic                 out_rfen,
  output logic [TNEW_W-1:0]    out_tnew,
  output logic [31:0]          out_pc,
  output logic                 out_wr_pending,
  output logic                 out_fwd_ok
);

  logic [TNEW_W-1:0] tnew_next;
  logic [31:0]       bubble_pc;

  // Tnew is counted at the upstream stage; one stage later it is one cycle
  // closer to ready, but never below zero.
  sat_dec #(
    .W(TNEW_W)
  ) u_tnew_dec (
    .dec_en (DEC_TNEW),
    .value  (in_tnew),
    .result (tnew_next)
  );

  // A bubble may keep the PC of the squashed instruction for EPC reporting.
  always_comb begin
    bubble_pc = KEEP_PC_ON_FLUSH ? in_pc : 32'h0;
  end

  // Stage state update: reset beats flush, flush beats load, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_a3      <= REG_ZERO;
      out_rfen    <= 1'b0;
      out_tnew    <= '0;
      out_pc      <= PC_RESET;
    end else if (flush) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
      out_a3      <= REG_ZERO;
      out_rfen    <= 1'b0;
      out_tnew    <= '0;
      out_pc      <= bubble_pc;
    end else if (en) begin
      out_valid   <= in_valid;
      out_payload <= in_payload;
      out_a3      <= in_a3;
      out_rfen    <= in_rfen & in_valid;
      out_tnew    <= tnew_next;
      out_pc      <= in_pc;
    end
  end

  // Hazard summaries for the forwarding and stall logic, from registered state.
  always_comb begin
    out_wr_pending = is_real_write(out_valid, out_rfen, out_a3);
    out_fwd_ok     = out_wr_pending & (out_tnew == '0);
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg. Two instances share the
// same inputs: one with defaults (DEC_TNEW=1, bubble PC=0) and one with
// DEC_TNEW=0 and KEEP_PC_ON_FLUSH=1.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic        in_valid;
  logic [63:0] in_payload;
  logic [4:0]  in_a3;
  logic        in_rfen;
  logic [2:0]  in_tnew;
  logic [31:0] in_pc;

  logic        o_valid, k_valid;
  logic [63:0] o_payload, k_payload;
  logic [4:0]  o_a3, k_a3;
  logic        o_rfen, k_rfen;
  logic [2:0]  o_tnew, k_tnew;
  logic [31:0] o_pc, k_pc;
  logic        o_wp, k_wp;
  logic        o_fwd, k_fwd;

  int vectors;
  int miscompares;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_a3(in_a3),
    .in_rfen(in_rfen), .in_tnew(in_tnew), .in_pc(in_pc),
    .out_valid(o_valid), .out_payload(o_payload), .out_a3(o_a3),
    .out_rfen(o_rfen), .out_tnew(o_tnew), .out_pc(o_pc),
    .out_wr_pending(o_wp), .out_fwd_ok(o_fwd)
  );

  pipe_stage_reg #(
    .DEC_TNEW(1'b0),
    .KEEP_PC_ON_FLUSH(1'b1)
  ) dut_keep (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .in_valid(in_valid), .in_payload(in_payload), .in_a3(in_a3),
    .in_rfen(in_rfen), .in_tnew(in_tnew), .in_pc(in_pc),
    .out_valid(k_valid), .out_payload(k_payload), .out_a3(k_a3),
    .out_rfen(k_rfen), .out_tnew(k_tnew), .out_pc(k_pc),
    .out_wr_pending(k_wp), .out_fwd_ok(k_fwd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one full set of data inputs.
  task automatic drive(input logic v, input logic [63:0] p, input logic [4:0] a3,
                       input logic rf, input logic [2:0] tn, input logic [31:0] pc);
    in_valid   = v;
    in_payload = p;
    in_a3      = a3;
    in_rfen    = rf;
    in_tnew    = tn;
    in_pc      = pc;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; flush = 1'b0;
    drive(1'b1, 64'h1111_2222_3333_4444, 5'd5, 1'b1, 3'd3, 32'h0000_4000);
    step();
    step();
    vectors++; if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", o_valid); end
    vectors++; if (o_payload !== 64'h0) begin miscompares++; $display("[TB] FAIL reset_payload got %h want 0", o_payload); end
    vectors++; if (o_a3 !== 5'd0 || o_rfen !== 1'b0 || o_tnew !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_fields got a3=%0d rfen=%b tnew=%0d want 0/0/0", o_a3, o_rfen, o_tnew); end
    vectors++; if (o_pc !== 32'h0000_3000) begin miscompares++; $display("[TB] FAIL reset_pc got %h want 00003000", o_pc); end
    vectors++; if (o_wp !== 1'b0 || o_fwd !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_hazard got wp=%b fwd=%b want 0/0", o_wp, o_fwd); end
    vectors++; if (k_pc !== 32'h0000_3000 || k_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_keep got pc=%h valid=%b want 00003000/0", k_pc, k_valid); end
    reset = 1'b0;
  endtask

  task automatic test_capture();
    en = 1'b1; flush = 1'b0;
    drive(1'b1, 64'h0000_0000_0000_1234, 5'd5, 1'b1, 3'd2, 32'h0000_3004);
    step();
    vectors++; if (o_tnew !== 3'd1 || o_a3 !== 5'd5) begin miscompares++; $display("[TB] FAIL cap_tnew2 got tnew=%0d a3=%0d want 1/5", o_tnew, o_a3); end
    vectors++; if (o_wp !== 1'b1 || o_fwd !== 1'b0) begin miscompares++; $display("[TB] FAIL cap_hazard2 got wp=%b fwd=%b want 1/0", o_wp, o_fwd); end
    vectors++; if (o_payload !== 64'h1234 || o_pc !== 32'h0000_3004 || o_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_data got payload=%h pc=%h valid=%b want 1234/00003004/1", o_payload, o_pc, o_valid); end
    vectors++; if (k_tnew !== 3'd2 || k_fwd !== 1'b0) begin miscompares++; $display("[TB] FAIL cap_nodec2 got tnew=%0d fwd=%b want 2/0", k_tnew, k_fwd); end
    drive(1'b1, 64'h0000_0000_0000_5678, 5'd5, 1'b1, 3'd1, 32'h0000_3008);
    step();
    vectors++; if (o_tnew !== 3'd0 || o_fwd !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_tnew1 got tnew=%0d fwd=%b want 0/1", o_tnew, o_fwd); end
    vectors++; if (k_tnew !== 3'd1 || k_fwd !== 1'b0) begin miscompares++; $display("[TB] FAIL cap_nodec1 got tnew=%0d fwd=%b want 1/0", k_tnew, k_fwd); end
    drive(1'b1, 64'h0000_0000_0000_9ABC, 5'd5, 1'b1, 3'd0, 32'h0000_300C);
    step();
    vectors++; if (o_tnew !== 3'd0 || o_fwd !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_tnew0 got tnew=%0d fwd=%b want 0/1", o_tnew, o_fwd); end
    vectors++; if (k_tnew !== 3'd0 || k_fwd !== 1'b1) begin miscompares++; $display("[TB] FAIL cap_nodec0 got tnew=%0d fwd=%b want 0/1", k_tnew, k_fwd); end
    drive(1'b1, 64'h0, 5'd31, 1'b1, 3'd7, 32'h0000_3010);
    step();
    vectors++; if (o_tnew !== 3'd6 || k_tnew !== 3'd7) begin miscompares++; $display("[TB] FAIL cap_tnew7 got dec=%0d nodec=%0d want 6/7", o_tnew, k_tnew); end
  endtask

  task automatic test_stall();
    en = 1'b1; flush = 1'b0;
    drive(1'b1, 64'hDEAD_BEEF_0000_0001, 5'd9, 1'b1, 3'd3, 32'h0000_3020);
    step();
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(i[0], 64'hFFFF_0000_FFFF_0000 ^ 64'(i), 5'(i + 20), 1'b0, 3'(i + 4), 32'h0000_5000 + 32'(i));
      step();
      vectors++; if (o_payload !== 64'hDEAD_BEEF_0000_0001 || o_pc !== 32'h0000_3020) begin miscompares++; $display("[TB] FAIL stall_data[%0d] got payload=%h pc=%h want deadbeef00000001/00003020", i, o_payload, o_pc); end
      vectors++; if (o_tnew !== 3'd2 || o_a3 !== 5'd9 || o_valid !== 1'b1 || o_rfen !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_ctl[%0d] got tnew=%0d a3=%0d valid=%b rfen=%b want 2/9/1/1", i, o_tnew, o_a3, o_valid, o_rfen); end
      vectors++; if (k_tnew !== 3'd3) begin miscompares++; $display("[TB] FAIL stall_keep_tnew[%0d] got %0d want 3", i, k_tnew); end
    end
  endtask

  task automatic test_flush_stall();
    en = 1'b0; flush = 1'b1;
    drive(1'b1, 64'h5555_5555_5555_5555, 5'd4, 1'b1, 3'd2, 32'h0000_3010);
    step();
    vectors++; if (o_valid !== 1'b0 || o_rfen !== 1'b0 || o_tnew !== 3'd0) begin miscompares++; $display("[TB] FAIL flush_ctl got valid=%b rfen=%b tnew=%0d want 0/0/0", o_valid, o_rfen, o_tnew); end
    vectors++; if (o_payload !== 64'h0 || o_a3 !== 5'd0) begin miscompares++; $display("[TB] FAIL flush_data got payload=%h a3=%0d want 0/0", o_payload, o_a3); end
    vectors++; if (o_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL flush_pc got %h want 0", o_pc); end
    vectors++; if (k_pc !== 32'h0000_3010 || k_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_keep_pc got pc=%h valid=%b want 00003010/0", k_pc, k_valid); end
    // Flush with en also asserted still inserts a bubble.
    en = 1'b1;
    drive(1'b1, 64'h7777, 5'd6, 1'b1, 3'd1, 32'h0000_3014);
    step();
    vectors++; if (o_valid !== 1'b0 || o_wp !== 1'b0 || o_payload !== 64'h0 || k_pc !== 32'h0000_3014) begin miscompares++; $display("[TB] FAIL flush_en got valid=%b wp=%b payload=%h kpc=%h want 0/0/0/00003014", o_valid, o_wp, o_payload, k_pc); end
    flush = 1'b0;
  endtask

  task automatic test_zero_invalid();
    en = 1'b1; flush = 1'b0;
    drive(1'b1, 64'h1, 5'd0, 1'b1, 3'd0, 32'h0000_3030);
    step();
    vectors++; if (o_wp !== 1'b0 || o_fwd !== 1'b0 || o_rfen !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_a3 got wp=%b fwd=%b rfen=%b want 0/0/1", o_wp, o_fwd, o_rfen); end
    drive(1'b0, 64'h2, 5'd7, 1'b1, 3'd0, 32'h0000_3034);
    step();
    vectors++; if (o_rfen !== 1'b0 || o_wp !== 1'b0 || o_a3 !== 5'd7 || o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL invalid_rfen got rfen=%b wp=%b a3=%0d valid=%b want 0/0/7/0", o_rfen, o_wp, o_a3, o_valid); end
  endtask

  task automatic test_reset_priority();
    en = 1'b1; flush = 1'b0;
    drive(1'b1, 64'hABCD, 5'd12, 1'b1, 3'd2, 32'h0000_3040);
    step();
    reset = 1'b1; flush = 1'b1; en = 1'b1;
    drive(1'b1, 64'hEF01, 5'd13, 1'b1, 3'd3, 32'h0000_3044);
    step();
    vectors++; if (o_valid !== 1'b0 || o_payload !== 64'h0 || o_a3 !== 5'd0 || o_tnew !== 3'd0) begin miscompares++; $display("[TB] FAIL rst_prio got valid=%b payload=%h a3=%0d tnew=%0d want 0/0/0/0", o_valid, o_payload, o_a3, o_tnew); end
    vectors++; if (o_pc !== 32'h0000_3000 || k_pc !== 32'h0000_3000) begin miscompares++; $display("[TB] FAIL rst_prio_pc got pc=%h kpc=%h want 00003000/00003000", o_pc, k_pc); end
    // Reset while stalled still clears the stage.
    reset = 1'b0; flush = 1'b0; en = 1'b1;
    drive(1'b1, 64'h4242, 5'd3, 1'b1, 3'd1, 32'h0000_3050);
    step();
    en = 1'b0; reset = 1'b1;
    step();
    vectors++; if (o_valid !== 1'b0 || o_payload !== 64'h0 || o_pc !== 32'h0000_3000 || o_rfen !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_stall got valid=%b payload=%h pc=%h rfen=%b want 0/0/00003000/0", o_valid, o_payload, o_pc, o_rfen); end
    reset = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1; en = 1'b0; flush = 1'b0;
    drive(1'b0, 64'h0, 5'd0, 1'b0, 3'd0, 32'h0);
    test_reset();
    test_capture();
    test_stall();
    test_flush_stall();
    test_zero_invalid();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
